tftp_rx_frame_sequencer: RTL and testbench



---
 rtl/tftp_rx_frame_sequencer_pkg.sv | 51 +++++
 rtl/tftp_rx_frame_buf.sv | 34 +++
 rtl/tftp_rx_frame_sequencer.sv | 285 ++++++++++++++++++++++++++++
 tb/tb_tftp_rx_frame_sequencer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tftp_rx_frame_sequencer_pkg.sv
// Shared definitions for the TFTP receive frame sequencer: protocol constants,
// byte offsets within an Ethernet/IPv4/UDP/TFTP frame, opcodes, state and
// frame-class encodings, and the opcode classifier.
package tftp_rx_frame_sequencer_pkg;

    // Header field values that an accepted frame must carry.
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  IPV4_VER_IHL   = 8'h45;
    localparam logic [7:0]  PROTO_UDP      = 8'h11;

    // 0-based byte offsets from the first destination MAC byte.
    localparam logic [7:0] OFF_ETYPE  = 8'd12;
    localparam logic [7:0] OFF_VIHL   = 8'd14;
    localparam logic [7:0] OFF_PROTO  = 8'd23;
    localparam logic [7:0] OFF_DPORT  = 8'd36;
    localparam logic [7:0] OFF_OPCODE = 8'd42;

    // TFTP opcodes are 16-bit; the high byte is always zero.
    localparam logic [7:0] OPCODE_HI = 8'h00;
    localparam logic [7:0] OP_RRQ    = 8'd1;
    localparam logic [7:0] OP_WRQ    = 8'd2;
    localparam logic [7:0] OP_DATA   = 8'd3;
    localparam logic [7:0] OP_ACK    = 8'd4;
    localparam logic [7:0] OP_ERR    = 8'd5;

    typedef enum logic [2:0] {
        StIdle,
        StCapture,
        StDiscard,
        StReplay,
        StFlush
    } state_e;

    typedef enum logic [1:0] {
        ClsNone,
        ClsReq,
        ClsAck
    } frame_cls_e;

    // Maps the opcode low byte to the class the decoder is told about.
    function automatic frame_cls_e opcode_class(input logic [7:0] op_lo);
        frame_cls_e cls;
        case (op_lo)
            OP_RRQ, OP_WRQ: cls = ClsReq;
            OP_ACK:         cls = ClsAck;
            default:        cls = ClsNone;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/tftp_rx_frame_buf.sv
// Frame store for the sequencer: DEPTH x 8 simple dual-port RAM.
// Ports:
//   clk    system clock
//   we     write enable; wdata is stored at waddr
//   waddr  write address
//   wdata  write data
//   re     read enable; rdata updates on the next clock edge
//   raddr  read address
//   rdata  registered read data
module tftp_rx_frame_buf #(
    parameter int unsigned DEPTH = 255,
    parameter int unsigned AW    = 8
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [7:0]    wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [7:0]    rdata
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/tftp_rx_frame_sequencer.sv
// Store-and-forward front end for the TFTP decode controller. Captures one
// Ethernet frame from the MAC byte stream, classifies it on the fly (IPv4, UDP,
// destination port, opcode) and replays accepted RRQ/WRQ/ACK frames as
// cnt/eth_data with req or ack held steady. Rejected frames are discarded.
// Ports:
//   clk         system clock
//   reset       asynchronous reset, active low
//   rx_valid    rx_data/rx_sof/rx_eof valid; taken only when rx_ready=1
//   rx_sof      first byte of frame
//   rx_eof      last byte of frame
//   rx_data     frame byte, destination MAC first
//   rx_ready    sequencer accepts a byte this cycle
//   local_port  active session UDP port, 0 = none
//   cnt         1-based replay byte index, 0 when not replaying
//   eth_data    replay byte matching cnt
//   req         replayed frame is RRQ/WRQ
//   ack         replayed frame is ACK
//   busy        sequencer not idle
//   frame_done  one-cycle pulse at the end of a replay
//   drop_cnt    saturating count of discarded frames
module tftp_rx_frame_sequencer
    import tftp_rx_frame_sequencer_pkg::*;
#(
    parameter int unsigned MAX_LEN   = 255,
    parameter int unsigned MIN_LEN   = 46,
    parameter logic [15:0] TFTP_PORT = 16'd69
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_valid,
    input  logic        rx_sof,
    input  logic        rx_eof,
    input  logic [7:0]  rx_data,
    output logic        rx_ready,
    input  logic [15:0] local_port,
    output logic [7:0]  cnt,
    output logic [7:0]  eth_data,
    output logic        req,
    output logic        ack,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  drop_cnt
);

    localparam logic [7:0] OFF_ETYPE_LO  = OFF_ETYPE + 8'd1;
    localparam logic [7:0] OFF_DPORT_LO  = OFF_DPORT + 8'd1;
    localparam logic [7:0] OFF_OPCODE_LO = OFF_OPCODE + 8'd1;

    state_e     state_q, state_d;
    frame_cls_e cls_q, cls_d, cls_nxt;
    logic [7:0] idx_q, idx_d;        // index of the next byte to be captured
    logic [7:0] len_q, len_d;
    logic [7:0] rd_idx_q, rd_idx_d;
    logic       rd_vld_q, rd_vld_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] eth_q, eth_d;
    logic       req_q, req_d;
    logic       ack_q, ack_d;
    logic       busy_q;
    logic       done_q, done_d;
    logic [7:0] drop_q;

    // Destination-port high-byte matches, held until the low byte arrives.
    logic       tftp_hi_q, tftp_hi_d;
    logic       local_hi_q, local_hi_d;
    logic [7:0] lport_lo_q, lport_lo_d;

    logic       acc;
    logic       byte_ok;
    logic       too_long;
    logic       len_ok;
    logic       hdr_upd;
    logic       drop_inc;
    logic       we;
    logic [7:0] waddr;
    logic       re;
    logic [7:0] rd_data;

    assign rx_ready = (state_q == StIdle) || (state_q == StCapture) || (state_q == StDiscard);
    assign acc      = rx_valid && rx_ready;
    assign too_long = {1'b0, idx_q} >= 9'(MAX_LEN);
    assign len_ok   = ({1'b0, idx_q} + 9'd1) >= 9'(MIN_LEN);

    assign cnt        = cnt_q;
    assign eth_data   = eth_q;
    assign req        = req_q;
    assign ack        = ack_q;
    assign busy       = busy_q;
    assign frame_done = done_q;
    assign drop_cnt   = drop_q;

    tftp_rx_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (8)
    ) u_buf (
        .clk   (clk),
        .we    (we),
        .waddr (waddr),
        .wdata (rx_data),
        .re    (re),
        .raddr (rd_idx_q),
        .rdata (rd_data)
    );

    // Header classifier: judges the byte at index idx_q.
    always_comb begin
        byte_ok    = 1'b1;
        cls_nxt    = cls_q;
        tftp_hi_d  = tftp_hi_q;
        local_hi_d = local_hi_q;
        lport_lo_d = lport_lo_q;
        case (idx_q)
            OFF_ETYPE:     byte_ok = (rx_data == ETHERTYPE_IPV4[15:8]);
            OFF_ETYPE_LO:  byte_ok = (rx_data == ETHERTYPE_IPV4[7:0]);
            OFF_VIHL:      byte_ok = (rx_data == IPV4_VER_IHL);
            OFF_PROTO:     byte_ok = (rx_data == PROTO_UDP);
            OFF_DPORT: begin
                // local_port is sampled here so later changes cannot alter this frame.
                tftp_hi_d  = (rx_data == TFTP_PORT[15:8]);
                local_hi_d = (local_port != 16'd0) && (rx_data == local_port[15:8]);
                lport_lo_d = local_port[7:0];
            end
            OFF_DPORT_LO: begin
                byte_ok = (tftp_hi_q && (rx_data == TFTP_PORT[7:0])) ||
                          (local_hi_q && (rx_data == lport_lo_q));
            end
            OFF_OPCODE:    byte_ok = (rx_data == OPCODE_HI);
            OFF_OPCODE_LO: begin
                cls_nxt = opcode_class(rx_data);
                byte_ok = (cls_nxt != ClsNone);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        len_d    = len_q;
        cls_d    = cls_q;
        rd_idx_d = rd_idx_q;
        rd_vld_d = 1'b0;
        re       = 1'b0;
        we       = 1'b0;
        waddr    = idx_q;
        hdr_upd  = 1'b0;
        drop_inc = 1'b0;
        cnt_d    = cnt_q;
        eth_d    = eth_q;
        req_d    = req_q;
        ack_d    = ack_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (acc && rx_sof) begin
                    we    = 1'b1;
                    waddr = 8'd0;
                    idx_d = 8'd1;
                    cls_d = ClsNone;
                    if (rx_eof) begin
                        drop_inc = 1'b1;
                    end else begin
                        state_d = StCapture;
                    end
                end
            end

            StCapture, StDiscard: begin
                if (acc && rx_sof) begin
                    // Restart on a fresh frame; the abandoned one counts as a drop.
                    drop_inc = 1'b1;
                    we       = 1'b1;
                    waddr    = 8'd0;
                    idx_d    = 8'd1;
                    cls_d    = ClsNone;
                    state_d  = rx_eof ? StIdle : StCapture;
                end else if (acc && (state_q == StDiscard)) begin
                    if (rx_eof) begin
                        drop_inc = 1'b1;
                        state_d  = StIdle;
                    end
                end else if (acc) begin
                    if (too_long || !byte_ok) begin
                        if (rx_eof) begin
                            drop_inc = 1'b1;
                            state_d  = StIdle;
                        end else begin
                            state_d = StDiscard;
                        end
                    end else begin
                        we      = 1'b1;
                        hdr_upd = 1'b1;
                        idx_d   = idx_q + 8'd1;
                        cls_d   = cls_nxt;
                        if (rx_eof) begin
                            // len >= MIN_LEN implies every header byte has been checked.
                            if (len_ok) begin
                                state_d  = StReplay;
                                len_d    = idx_q + 8'd1;
                                rd_idx_d = 8'd0;
                            end else begin
                                drop_inc = 1'b1;
                                state_d  = StIdle;
                            end
                        end
                    end
                end
            end

            StReplay: begin
                // Reads run one cycle ahead of the outputs to hide RAM latency.
                if (rd_idx_q != len_q) begin
                    re       = 1'b1;
                    rd_idx_d = rd_idx_q + 8'd1;
                    rd_vld_d = 1'b1;
                end
                if (rd_vld_q) begin
                    cnt_d = cnt_q + 8'd1;
                    eth_d = rd_data;
                    req_d = (cls_q == ClsReq);
                    ack_d = (cls_q == ClsAck);
                end else if (cnt_q == len_q) begin
                    state_d = StFlush;
                    cnt_d   = 8'd0;
                    eth_d   = 8'd0;
                    done_d  = 1'b1;
                end
            end

            StFlush: begin
                state_d = StIdle;
                req_d   = 1'b0;
                ack_d   = 1'b0;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            cls_q      <= ClsNone;
            idx_q      <= 8'd0;
            len_q      <= 8'd0;
            rd_idx_q   <= 8'd0;
            rd_vld_q   <= 1'b0;
            cnt_q      <= 8'd0;
            eth_q      <= 8'd0;
            req_q      <= 1'b0;
            ack_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 8'd0;
            tftp_hi_q  <= 1'b0;
            local_hi_q <= 1'b0;
            lport_lo_q <= 8'd0;
        end else begin
            state_q  <= state_d;
            cls_q    <= cls_d;
            idx_q    <= idx_d;
            len_q    <= len_d;
            rd_idx_q <= rd_idx_d;
            rd_vld_q <= rd_vld_d;
            cnt_q    <= cnt_d;
            eth_q    <= eth_d;
            req_q    <= req_d;
            ack_q    <= ack_d;
            busy_q   <= (state_d != StIdle);
            done_q   <= done_d;
            if (drop_inc && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (hdr_upd) begin
                tftp_hi_q  <= tftp_hi_d;
                local_hi_q <= local_hi_d;
                lport_lo_q <= lport_lo_d;
            end
        end
    end

endmodule

// File: tb/tb_tftp_rx_frame_sequencer.sv
module tb_tftp_rx_frame_sequencer;

    logic        clk;
    logic        reset;
    logic        rx_valid;
    logic        rx_sof;
    logic        rx_eof;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic [15:0] local_port;
    logic [7:0]  cnt;
    logic [7:0]  eth_data;
    logic        req;
    logic        ack;
    logic        busy;
    logic        frame_done;
    logic [7:0]  drop_cnt;

    tftp_rx_frame_sequencer #(
        .MAX_LEN   (255),
        .MIN_LEN   (46),
        .TFTP_PORT (16'd69)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_valid   (rx_valid),
        .rx_sof     (rx_sof),
        .rx_eof     (rx_eof),
        .rx_data    (rx_data),
        .rx_ready   (rx_ready),
        .local_port (local_port),
        .cnt        (cnt),
        .eth_data   (eth_data),
        .req        (req),
        .ack        (ack),
        .busy       (busy),
        .frame_done (frame_done),
        .drop_cnt   (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0] cnt;
        logic [7:0] data;
        logic       req;
        logic       ack;
    } exp_t;

    exp_t       exp_q [$];
    logic [1:0] done_q [$];   // {req, ack} expected during the frame_done cycle
    exp_t       e;
    logic [1:0] d;
    bit         post_done;

    int n_cmp;
    int n_fail;
    int exp_drop;
    bit stall_seen;

    logic [7:0] fr [0:299];
    int         fr_len;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected entry whenever the DUT presents a byte.
    always @(negedge clk) begin
        if (reset) begin
            if (post_done) begin
                check("req_ack_clear", {30'd0, req, ack}, 32'd0);
                post_done = 1'b0;
            end
            if (cnt != 8'd0) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_replay", {24'd0, cnt}, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("replay", {13'd0, cnt, eth_data, req, ack, rx_ready},
                          {13'd0, e.cnt, e.data, e.req, e.ack, 1'b0});
                end
            end
            if (frame_done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", 32'd1, 32'd0);
                end else begin
                    d = done_q.pop_front();
                    check("frame_done", {14'd0, cnt, eth_data, req, ack},
                          {14'd0, 8'd0, 8'd0, d[1], d[0]});
                    post_done = 1'b1;
                end
            end
        end else begin
            post_done = 1'b0;
        end
    end

    task automatic build(input int len, input logic [15:0] etype, input logic [7:0] vihl,
                         input logic [7:0] proto, input logic [15:0] dport,
                         input logic [15:0] opcode, input int seed);
        fr_len = len;
        for (int i = 0; i < len; i++) fr[i] = 8'((i * 5 + seed) & 255);
        if (len > 13) begin fr[12] = etype[15:8]; fr[13] = etype[7:0]; end
        if (len > 14) fr[14] = vihl;
        if (len > 23) fr[23] = proto;
        if (len > 37) begin fr[36] = dport[15:8]; fr[37] = dport[7:0]; end
        if (len > 43) begin fr[42] = opcode[15:8]; fr[43] = opcode[7:0]; end
    endtask

    task automatic drive(input logic [7:0] dat, input logic sof, input logic eof);
        int g;
        g = 0;
        while (!rx_ready && g < 1000) begin
            stall_seen = 1'b1;
            @(negedge clk);
            g++;
        end
        if (g >= 1000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL rx_ready_timeout: rx_ready stuck at 0");
        end
        rx_valid = 1'b1;
        rx_data  = dat;
        rx_sof   = sof;
        rx_eof   = eof;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_sof   = 1'b0;
        rx_eof   = 1'b0;
    endtask

    // Sends the first 'upto' bytes of fr; eof only when the whole frame is sent.
    task automatic send(input int upto, input bit gaps);
        for (int i = 0; i < upto; i++) begin
            if (gaps && (i % 5 == 3)) repeat (i % 3 + 1) @(negedge clk);
            drive(fr[i], i == 0, (upto == fr_len) && (i == fr_len - 1));
        end
    endtask

    task automatic expect_replay(input bit is_req);
        exp_t x;
        for (int i = 1; i <= fr_len; i++) begin
            x.cnt  = 8'(i);
            x.data = fr[i-1];
            x.req  = is_req;
            x.ack  = !is_req;
            exp_q.push_back(x);
        end
        done_q.push_back({is_req, !is_req});
    endtask

    task automatic expect_drop();
        exp_drop = (exp_drop == 255) ? 255 : exp_drop + 1;
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        while ((busy || !rx_ready) && g < 2000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 2000) begin
            n_cmp++;
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b rx_ready=%0b", busy, rx_ready);
        end
        @(negedge clk);
    endtask

    initial begin
        int g;
        n_cmp      = 0;
        n_fail     = 0;
        exp_drop   = 0;
        post_done  = 1'b0;
        stall_seen = 1'b0;
        reset      = 1'b0;
        rx_valid   = 1'b0;
        rx_sof     = 1'b0;
        rx_eof     = 1'b0;
        rx_data    = 8'd0;
        local_port = 16'd0;
        repeat (3) @(negedge clk);
        check("reset_state", {3'd0, cnt, eth_data, req, ack, busy, frame_done, drop_cnt, rx_ready},
              {3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1});
        reset = 1'b1;
        @(negedge clk);

        // 62-byte RRQ on the well-known port, with first-byte latency check.
        build(62, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 1);
        expect_replay(1'b1);
        send(62, 1'b0);
        check("latency_c0", {24'd0, cnt}, 32'd0);
        @(negedge clk);
        check("latency_c1", {24'd0, cnt}, 32'd0);
        @(negedge clk);
        check("latency_c2", {24'd0, cnt}, 32'd1);
        wait_idle();

        // 60-byte ACK to an active session port, then same frame with no session.
        local_port = 16'h1234;
        build(60, 16'h0800, 8'h45, 8'h11, 16'h1234, 16'h0004, 7);
        expect_replay(1'b0);
        send(60, 1'b0);
        wait_idle();
        local_port = 16'd0;
        send(60, 1'b0);
        expect_drop();
        wait_idle();
        check("drop_port", {24'd0, drop_cnt}, exp_drop);

        // ARP ethertype, then a DATA opcode: both dropped, busy low after eof.
        build(60, 16'h0806, 8'h45, 8'h11, 16'd69, 16'h0001, 9);
        send(60, 1'b0);
        expect_drop();
        check("busy_after_arp", {31'd0, busy}, 32'd0);
        build(60, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0003, 13);
        send(60, 1'b0);
        expect_drop();
        check("busy_after_data", {31'd0, busy}, 32'd0);
        check("drop_hdr", {24'd0, drop_cnt}, exp_drop);

        // Too short, then too long.
        build(40, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 17);
        send(40, 1'b0);
        expect_drop();
        check("drop_short", {24'd0, drop_cnt}, exp_drop);
        build(256, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 21);
        stall_seen = 1'b0;
        send(256, 1'b0);
        expect_drop();
        check("long_no_stall", {31'd0, stall_seen}, 32'd0);
        check("drop_long", {24'd0, drop_cnt}, exp_drop);
        check("idle_after_long", {30'd0, busy, rx_ready}, 32'd1);

        // Abandoned frame at b20, then a full RRQ delivered with valid gaps.
        build(62, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 3);
        send(20, 1'b0);
        build(62, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0002, 11);
        expect_drop();
        expect_replay(1'b1);
        send(62, 1'b1);
        wait_idle();
        check("drop_restart", {24'd0, drop_cnt}, exp_drop);

        // Asynchronous reset mid-replay.
        build(62, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 5);
        expect_replay(1'b1);
        send(62, 1'b0);
        g = 0;
        while (cnt != 8'd30 && g < 200) begin
            @(negedge clk);
            g++;
        end
        check("reach_cnt30", {24'd0, cnt}, 32'd30);
        #2 reset = 1'b0;
        #1;
        check("async_reset", {3'd0, cnt, eth_data, req, ack, busy, frame_done, drop_cnt, rx_ready},
              {3'd0, 8'd0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1});
        exp_q.delete();
        done_q.delete();
        exp_drop = 0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        build(62, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 29);
        expect_replay(1'b1);
        send(62, 1'b0);
        wait_idle();

        // Saturation of the drop counter.
        build(2, 16'h0800, 8'h45, 8'h11, 16'd69, 16'h0001, 31);
        for (int i = 0; i < 300; i++) begin
            send(2, 1'b0);
            expect_drop();
            if (i == 253) check("drop_254", {24'd0, drop_cnt}, exp_drop);
        end
        check("drop_sat", {24'd0, drop_cnt}, exp_drop);

        wait_idle();
        check("leftover_bytes", exp_q.size(), 32'd0);
        check("leftover_done", done_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
